// File: rtl/fc_stream_pkg.sv
// Shared stream types for FC layers and inter-layer blocks.
// Word width default, signed word type, bank index type.
package fc_stream_pkg;

  localparam int FC_WIDTH = 16;

  typedef logic signed [FC_WIDTH-1:0] fc_word_t;
  typedef logic bank_t;

  function automatic logic [1:0] bank_onehot(
    input bank_t b
  );
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One frame bank: DEPTH x WIDTH registers.
// Ports: clk, sync write (wr_en/wr_addr/wr_data), comb read (rd_addr/rd_data).
module pingpong_bank #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [LOGDEPTH-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0]    wr_data,
  input  logic [LOGDEPTH-1:0]        rd_addr,
  output logic signed [WIDTH-1:0]    rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fc_layer_pingpong_buffer.sv
// Two-bank frame buffer between FC layers: write one frame, replay the other.
// Ports: clk, reset, input_{valid,ready,data}, output_{valid,ready,data}, frames_full.
module fc_layer_pingpong_buffer
  import fc_stream_pkg::*;
#(
  parameter  int WIDTH    = FC_WIDTH,
  parameter  int DEPTH    = 8,
  localparam int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic signed [WIDTH-1:0] input_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic signed [WIDTH-1:0] output_data,
  output logic [1:0]              frames_full
);

  localparam logic [LOGDEPTH-1:0] LAST =
    LOGDEPTH'(DEPTH - 1);

  logic [1:0]          full;
  logic [1:0]          full_set;
  logic [1:0]          full_clr;
  bank_t               wr_bank;
  bank_t               rd_bank;
  logic [LOGDEPTH-1:0] wr_addr;
  logic [LOGDEPTH-1:0] rd_addr;
  logic                wr_fire;
  logic                wr_last;
  logic                load;
  logic                rd_last;
  logic signed [WIDTH-1:0] rd_data0;
  logic signed [WIDTH-1:0] rd_data1;
  logic signed [WIDTH-1:0] rd_word;

  assign input_ready = !full[wr_bank];
  assign wr_fire     = input_valid && input_ready;
  assign wr_last     = (wr_addr == LAST);
  assign rd_last     = (rd_addr == LAST);
  assign load        = full[rd_bank] &&
                       (!output_valid || output_ready);

  // Write and read never target the same bank's flag
  // in one cycle: a bank is read only once it is full,
  // and written only while it is not.
  assign full_set = (wr_fire && wr_last) ?
                    bank_onehot(wr_bank) : 2'b00;
  assign full_clr = (load && rd_last) ?
                    bank_onehot(rd_bank) : 2'b00;

  assign frames_full = {1'b0, full[0]} + {1'b0, full[1]};
  assign rd_word     = rd_bank ? rd_data1 : rd_data0;

  pingpong_bank #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .LOGDEPTH (LOGDEPTH)
  ) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire && (wr_bank == 1'b0)),
    .wr_addr (wr_addr),
    .wr_data (input_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  pingpong_bank #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .LOGDEPTH (LOGDEPTH)
  ) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_fire && (wr_bank == 1'b1)),
    .wr_addr (wr_addr),
    .wr_data (input_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      full         <= 2'b00;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;

      if (wr_fire) begin
        if (wr_last) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + LOGDEPTH'(1);
        end
      end

      if (load) begin
        output_data  <= rd_word;
        output_valid <= 1'b1;
        if (rd_last) begin
          rd_addr <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_addr <= rd_addr + LOGDEPTH'(1);
        end
      end else if (output_valid && output_ready) begin
        output_valid <= 1'b0;
      end
    end
  end

endmodule
